quad_decoder_counter: RTL

- Quadrature decoder: reads the two-phase A/B signals of an incremental encoder and drives an up/down position counter.
- The counter supports load and clear, like the team's existing up/down counters.
- It is the receive/decode end of the encoder interface and supplies position, direction and step strobes to downstream control logic.
- A/B are asynchronous to clk. Each phase is synchronized and glitch-filtered before decoding.

---
 rtl/quad_pkg.sv | 40 ++++
 rtl/quad_decoder_counter_if.sv | 19 +
 rtl/quad_filter.sv | 40 ++++
 rtl/quad_decoder_counter.sv | 92 +++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and the quadrature decode function for the encoder receive path.
// Phase states are written {a,b}; the forward sequence is 00 -> 10 -> 11 -> 01 -> 00.
package quad_pkg;

  typedef enum logic {INIT, RUN} state_t;

  typedef enum logic [1:0] {NONE, INC, DEC, ILLEGAL} dec_t;

  localparam logic [1:0] PH00 = 2'b00;
  localparam logic [1:0] PH10 = 2'b10;
  localparam logic [1:0] PH11 = 2'b11;
  localparam logic [1:0] PH01 = 2'b01;

  // Position of a phase state within one forward electrical cycle.
  function automatic logic [1:0] phase_idx(input logic [1:0] ph);
    logic [1:0] idx;
    case (ph)
      PH00:    idx = 2'd0;
      PH10:    idx = 2'd1;
      PH11:    idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // A one-position move forward is INC, backward is DEC, two positions is ILLEGAL.
  function automatic dec_t decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    dec_t       r;
    d = phase_idx(cur) - phase_idx(prev);
    case (d)
      2'd0:    r = NONE;
      2'd1:    r = INC;
      2'd3:    r = DEC;
      default: r = ILLEGAL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder_counter_if.sv
// Encoder phases, counter control and position/status outputs of the quadrature decoder.
// master = the side driving encoder phases and control, slave = the decoder itself.
interface quad_decoder_counter_if #(parameter int N = 8);
  logic         a_in;
  logic         b_in;
  logic         ld;
  logic [N-1:0] d_in;
  logic         err_clr;
  logic [N-1:0] count;
  logic         dir;
  logic         step;
  logic         wrap;
  logic         err;

  modport master (output a_in, b_in, ld, d_in, err_clr,
                  input  count, dir, step, wrap, err);
  modport slave  (input  a_in, b_in, ld, d_in, err_clr,
                  output count, dir, step, wrap, err);
endinterface

// File: rtl/quad_filter.sv
// Purpose: two-flop synchronizer plus stability filter for one asynchronous encoder phase.
// Latency: a new level sampled at edge 0 appears on filt at edge FILT+1.
// Backpressure: none; free-running, pulses shorter than FILT cycles are dropped.
module quad_filter #(
  parameter int FILT = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic raw,
  output logic filt
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // cnt tracks how long the synchronized level has disagreed with filt
      if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder_counter.sv
// Purpose: quadrature decoder driving a loadable N-bit up/down position counter.
// Latency: count/step/wrap update FILT+2 edges after a phase change is first sampled.
// Backpressure: none; every accepted step is applied, ld overrides a coincident step.
module quad_decoder_counter
  import quad_pkg::*;
#(
  parameter int N    = 8,
  parameter int FILT = 2
) (
  input  logic                      clk,
  input  logic                      clear,
  quad_decoder_counter_if.slave     bus
);

  localparam int             TW    = $clog2(FILT + 3);
  localparam logic [TW-1:0]  T_EXP = TW'(FILT + 2);

  state_t         state_q;
  state_t         state_d;
  logic [TW-1:0]  tmr;
  logic           fa;
  logic           fb;
  logic [1:0]     cur;
  logic [1:0]     prev;
  dec_t           res;
  logic [N-1:0]   count_q;
  logic           dir_q;
  logic           step_q;
  logic           wrap_q;
  logic           err_q;

  quad_filter #(.FILT(FILT)) u_filt_a (.clk, .clear, .raw(bus.a_in), .filt(fa));
  quad_filter #(.FILT(FILT)) u_filt_b (.clk, .clear, .raw(bus.b_in), .filt(fb));

  assign cur = {fa, fb};

  always_ff @(posedge clk) begin
    if (clear) state_q <= INIT;
    else       state_q <= state_d;
  end

  // INIT waits until the filters have settled on the resting phase before decoding.
  always_comb begin
    state_d = state_q;
    res     = NONE;
    case (state_q)
      INIT: if (tmr == T_EXP) state_d = RUN;
      RUN:  res = decode(prev, cur);
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      tmr     <= '0;
      prev    <= PH00;
      count_q <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (state_q == INIT && tmr != T_EXP) tmr <= tmr + 1'b1;
      if (state_d == RUN) prev <= cur;

      if (bus.ld) begin
        count_q <= bus.d_in;
      end else if (res == INC) begin
        count_q <= count_q + 1'b1;
        dir_q   <= 1'b1;
        step_q  <= 1'b1;
        wrap_q  <= (count_q == {N{1'b1}});
      end else if (res == DEC) begin
        count_q <= count_q - 1'b1;
        dir_q   <= 1'b0;
        step_q  <= 1'b1;
        wrap_q  <= (count_q == '0);
      end

      if (res == ILLEGAL)   err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.step  = step_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;

endmodule
